instr_encoder_loader: RTL and testbench

Encoder counterpart to the MIPS control unit's decoder. It accepts symbolic instruction commands over a valid/ready handshake, assembles the 32-bit MIPS word, and writes it to instruction memory at sequential word addresses. Bring-up and test logic use it to load programs without an external assembler. The opcode/funct encodings are exactly those our decoder recognises, including SRA funct 001011.

---
 rtl/instr_encoder_loader.sv | 203 ++++++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder_loader
// Purpose  : Takes symbolic MIPS instruction commands over a valid/ready
//            handshake, assembles the 32-bit instruction word and writes it
//            to instruction memory at sequential word addresses.
// Ports    : clk, reset (async, active-low), start (sync clear pulse)
//            cmd_*          - command handshake and instruction fields
//            ins_mem_*      - instruction-memory write port
//            busy/done/err  - status (done and err are sticky)
//            count          - number of words written since start/reset
// Revision : 1.0 - initial release
// ============================================================================
module instr_encoder_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [4:0]        cmd_op,
  input  logic [4:0]        cmd_rs,
  input  logic [4:0]        cmd_rt,
  input  logic [4:0]        cmd_rd,
  input  logic [4:0]        cmd_shamt,
  input  logic [15:0]       cmd_imm,
  input  logic [25:0]       cmd_target,
  input  logic              cmd_last,
  output logic              ins_mem_wr_en,
  output logic [ADDR_W-1:0] ins_mem_addr,
  output logic [31:0]       ins_mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] c_addr_max  = '1;
  localparam logic [ADDR_W:0]   c_count_one = (ADDR_W+1)'(1);

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_count;
  logic [31:0]       r_wdata;
  logic              r_last;
  logic              r_done;
  logic              r_err;

  logic              w_handshake;
  logic              w_at_max;
  logic              w_finish;
  logic              w_op_valid;
  logic              w_is_r;
  logic              w_is_j;
  logic              w_is_shift;
  logic [5:0]        w_code;
  logic [31:0]       w_word;

  // --------------------------------------------------------------------------
  // Encoder: w_code is the funct for R-type ops and the opcode otherwise.
  // --------------------------------------------------------------------------
  always_comb begin
    w_op_valid = 1'b1;
    w_is_r     = 1'b0;
    w_is_j     = 1'b0;
    w_is_shift = 1'b0;
    w_code     = 6'b000000;
    case (cmd_op)
      5'd0:  begin w_is_r = 1'b1; w_code = 6'b100000; end
      5'd1:  begin w_is_r = 1'b1; w_code = 6'b100001; end
      5'd2:  begin w_is_r = 1'b1; w_code = 6'b100010; end
      5'd3:  begin w_is_r = 1'b1; w_code = 6'b100011; end
      5'd4:  begin w_is_r = 1'b1; w_code = 6'b100100; end
      5'd5:  begin w_is_r = 1'b1; w_code = 6'b100101; end
      5'd6:  begin w_is_r = 1'b1; w_code = 6'b100110; end
      5'd7:  begin w_is_r = 1'b1; w_code = 6'b100111; end
      5'd8:  begin w_is_r = 1'b1; w_code = 6'b101010; end
      5'd9:  begin w_is_r = 1'b1; w_code = 6'b101011; end
      5'd10: begin w_is_r = 1'b1; w_is_shift = 1'b1; w_code = 6'b000000; end
      5'd11: begin w_is_r = 1'b1; w_is_shift = 1'b1; w_code = 6'b000010; end
      5'd12: begin w_is_r = 1'b1; w_is_shift = 1'b1; w_code = 6'b001011; end
      5'd13: w_code = 6'b100011;
      5'd14: w_code = 6'b100001;
      5'd15: w_code = 6'b100000;
      5'd16: w_code = 6'b101011;
      5'd17: w_code = 6'b101001;
      5'd18: w_code = 6'b101000;
      5'd19: w_code = 6'b001000;
      5'd20: w_code = 6'b001100;
      5'd21: w_code = 6'b001101;
      5'd22: w_code = 6'b001110;
      5'd23: w_code = 6'b001010;
      5'd24: w_code = 6'b001011;
      5'd25: w_code = 6'b000100;
      5'd26: w_code = 6'b000101;
      5'd27: begin w_is_j = 1'b1; w_code = 6'b000010; end
      default: w_op_valid = 1'b0;
    endcase

    // Shifts take their operand from rt, so rs is zeroed; only shifts
    // carry a shift amount.
    if (w_is_r) begin
      w_word = {6'b000000,
                w_is_shift ? 5'd0 : cmd_rs,
                cmd_rt,
                cmd_rd,
                w_is_shift ? cmd_shamt : 5'd0,
                w_code};
    end else if (w_is_j) begin
      w_word = {w_code, cmd_target};
    end else begin
      w_word = {w_code, cmd_rs, cmd_rt, cmd_imm};
    end
  end

  assign cmd_ready   = (r_state == ST_IDLE);
  assign w_handshake = cmd_valid & cmd_ready;
  assign w_at_max    = (r_addr == c_addr_max);
  // The last address forces completion so the address never wraps.
  assign w_finish    = r_last | w_at_max;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (start) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_handshake) w_state_next = w_op_valid ? ST_WRITE : ST_ERR;
        ST_WRITE: w_state_next = w_finish ? ST_DONE : ST_IDLE;
        default:  w_state_next = r_state;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Datapath and sticky status. start takes priority; in WRITE the strobe is
  // Moore so the pending write still lands at the old address that cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr  <= '0;
      r_count <= '0;
      r_wdata <= '0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else if (start) begin
      r_addr  <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_handshake) begin
            if (w_op_valid) begin
              r_wdata <= w_word;
              r_last  <= cmd_last;
            end else begin
              r_err   <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          r_count <= r_count + c_count_one;
          if (!w_at_max) r_addr <= r_addr + 1'b1;
          if (w_finish)  r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ins_mem_wr_en = (r_state == ST_WRITE);
  assign busy          = (r_state == ST_WRITE);
  assign ins_mem_addr  = r_addr;
  assign ins_mem_wdata = r_wdata;
  assign done          = r_done;
  assign err           = r_err;
  assign count         = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_encoder_loader
// Purpose  : Self-checking bench for instr_encoder_loader (ADDR_W=8 main
//            instance plus an ADDR_W=2 instance for the capacity case).
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_valid2 = 1'b0;
  logic [4:0]  cmd_op = '0, cmd_rs = '0, cmd_rt = '0, cmd_rd = '0, cmd_shamt = '0;
  logic [15:0] cmd_imm = '0;
  logic [25:0] cmd_target = '0;
  logic        cmd_last = 1'b0;

  logic        cmd_ready, wr_en, busy, done, err;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [8:0]  count;

  logic        cmd_ready2, wr_en2, busy2, done2, err2;
  logic [1:0]  addr2;
  logic [31:0] wdata2;
  logic [2:0]  count2;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state of the main instance.
  int m_addr  = 0;
  int m_count = 0;
  bit m_done  = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(8)) u_dut (
    .clk(clk), .reset(reset), .start(start),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
    .cmd_shamt(cmd_shamt), .cmd_imm(cmd_imm), .cmd_target(cmd_target),
    .cmd_last(cmd_last),
    .ins_mem_wr_en(wr_en), .ins_mem_addr(addr), .ins_mem_wdata(wdata),
    .busy(busy), .done(done), .err(err), .count(count)
  );

  instr_encoder_loader #(.ADDR_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start),
    .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_op(cmd_op), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
    .cmd_shamt(cmd_shamt), .cmd_imm(cmd_imm), .cmd_target(cmd_target),
    .cmd_last(cmd_last),
    .ins_mem_wr_en(wr_en2), .ins_mem_addr(addr2), .ins_mem_wdata(wdata2),
    .busy(busy2), .done(done2), .err(err2), .count(count2)
  );

  // Instruction word from the op table, built by weighted field sums.
  function automatic logic [31:0] ref_word(input int op, input int rs, input int rt,
                                           input int rd, input int sh, input int imm,
                                           input int tgt);
    int     functs [0:12];
    int     opcs   [0:13];
    longint w;
    functs = '{32, 33, 34, 35, 36, 37, 38, 39, 42, 43, 0, 2, 11};
    opcs   = '{35, 33, 32, 43, 41, 40, 8, 12, 13, 14, 10, 11, 4, 5};
    if (op <= 12) begin
      if (op >= 10) w = rt * 65536 + rd * 2048 + sh * 64 + functs[op];
      else          w = rs * 2097152 + rt * 65536 + rd * 2048 + functs[op];
    end else if (op <= 26) begin
      w = longint'(opcs[op - 13]) * 67108864 + rs * 2097152 + rt * 65536 + imm;
    end else begin
      w = 2 * 67108864 + tgt;
    end
    return w[31:0];
  endfunction

  task automatic set_fields(input int op, input int rs, input int rt, input int rd,
                            input int sh, input int imm, input int tgt, input bit last);
    cmd_op = op[4:0]; cmd_rs = rs[4:0]; cmd_rt = rt[4:0]; cmd_rd = rd[4:0];
    cmd_shamt = sh[4:0]; cmd_imm = imm[15:0]; cmd_target = tgt[25:0]; cmd_last = last;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    m_addr = 0; m_count = 0; m_done = 0;
  endtask

  // One accepted command on the main instance, checked through its write.
  task automatic issue(input int op, input int rs, input int rt, input int rd,
                       input int sh, input int imm, input int tgt, input bit last,
                       input logic [31:0] exp_word);
    bit exp_done;
    @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL ready_before: got %b want 1", cmd_ready); end
    set_fields(op, rs, rt, rd, sh, imm, tgt, last);
    cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    n_cmp++; if (wr_en !== 1'b1) begin n_bad++; $display("FAIL wr_en_pulse op%0d: got %b want 1", op, wr_en); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL busy op%0d: got %b want 1", op, busy); end
    n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL ready_in_write: got %b want 0", cmd_ready); end
    n_cmp++; if (addr !== m_addr[7:0]) begin n_bad++; $display("FAIL addr op%0d: got %0d want %0d", op, addr, m_addr); end
    n_cmp++; if (wdata !== exp_word) begin n_bad++; $display("FAIL wdata op%0d: got %h want %h", op, wdata, exp_word); end
    exp_done = last || (m_addr == 255);
    @(posedge clk); #1;
    m_count++;
    if (m_addr != 255) m_addr++;
    m_done = exp_done;
    n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL wr_en_drop op%0d: got %b want 0", op, wr_en); end
    n_cmp++; if (count !== m_count[8:0]) begin n_bad++; $display("FAIL count: got %0d want %0d", count, m_count); end
    n_cmp++; if (done !== m_done) begin n_bad++; $display("FAIL done: got %b want %b", done, m_done); end
    n_cmp++; if (cmd_ready !== !m_done) begin n_bad++; $display("FAIL ready_after: got %b want %b", cmd_ready, !m_done); end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if ({wr_en, busy, done, err} !== 4'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {wr_en, busy, done, err}); end
    n_cmp++; if (addr !== 8'd0 || count !== 9'd0) begin n_bad++; $display("FAIL reset_addr_count: got %0d/%0d want 0/0", addr, count); end
    n_cmp++; if (wdata !== 32'd0) begin n_bad++; $display("FAIL reset_wdata: got %h want 0", wdata); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
    m_addr = 0; m_count = 0; m_done = 0;
  endtask

  task automatic test_add();
    issue(0, 1, 2, 3, 5, 0, 0, 0, 32'h0022_1820);
  endtask

  task automatic test_lw_sra();
    pulse_start();
    issue(13, 29, 8, 0, 0, 16'h0004, 0, 0, 32'h8FA8_0004);
    issue(12, 7, 5, 4, 2, 0, 0, 1, 32'h0005_208B);
    // Commands are ignored in DONE.
    @(negedge clk); cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL done_ignores: got %b want 0", wr_en); end
    end
    cmd_valid = 1'b0;
    n_cmp++; if (count !== 9'd2) begin n_bad++; $display("FAIL done_count: got %0d want 2", count); end
  endtask

  task automatic test_back_to_back();
    pulse_start();
    @(negedge clk);
    set_fields(27, 0, 0, 0, 0, 0, 26'h10, 0);
    cmd_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (wr_en !== ((i % 2) == 0)) begin n_bad++; $display("FAIL b2b_wr_en cyc%0d: got %b want %b", i, wr_en, (i % 2) == 0); end
      if ((i % 2) == 0) begin
        n_cmp++; if (addr !== 8'(i / 2)) begin n_bad++; $display("FAIL b2b_addr: got %0d want %0d", addr, i / 2); end
        n_cmp++; if (wdata !== 32'h0800_0010) begin n_bad++; $display("FAIL b2b_wdata: got %h want 08000010", wdata); end
      end
    end
    cmd_valid = 1'b0;
    m_addr = 3; m_count = 3;
    n_cmp++; if (count !== 9'd3) begin n_bad++; $display("FAIL b2b_count: got %0d want 3", count); end
  endtask

  task automatic test_err();
    @(negedge clk);
    set_fields(30, 1, 2, 3, 0, 0, 0, 0);
    cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b want 1", err); end
    n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL err_no_write: got %b want 0", wr_en); end
    n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL err_ready: got %b want 0", cmd_ready); end
    @(negedge clk); cmd_op = 5'd0; cmd_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL err_ignores: got %b want 0", wr_en); end
    end
    cmd_valid = 1'b0;
    pulse_start();
    n_cmp++; if (err !== 1'b0 || addr !== 8'd0) begin n_bad++; $display("FAIL err_clear: got err=%b addr=%0d want 0/0", err, addr); end
    issue(0, 1, 2, 3, 5, 0, 0, 0, 32'h0022_1820);
  endtask

  task automatic test_start_collision();
    pulse_start();
    @(negedge clk);
    set_fields(1, 4, 5, 6, 0, 0, 0, 0);
    cmd_valid = 1'b1; start = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (wr_en !== 1'b0 || count !== 9'd0) begin n_bad++; $display("FAIL start_wins: got wr=%b cnt=%0d want 0/0", wr_en, count); end
  endtask

  task automatic test_random();
    int op, rs, rt, rd, sh, imm, tgt;
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      op = $urandom_range(0, 27);
      rs = $urandom_range(0, 31); rt = $urandom_range(0, 31); rd = $urandom_range(0, 31);
      sh = $urandom_range(0, 31); imm = $urandom_range(0, 65535);
      tgt = $urandom_range(0, 67108863);
      issue(op, rs, rt, rd, sh, imm, tgt, i == 19, ref_word(op, rs, rt, rd, sh, imm, tgt));
    end
  endtask

  task automatic test_capacity();
    logic [31:0] exp_w;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_fields(19, i, i + 1, 0, 0, 16'h1000 + i, 0, 0);
      exp_w = ref_word(19, i, i + 1, 0, 0, 16'h1000 + i, 0);
      cmd_valid2 = 1'b1;
      @(posedge clk); #1 cmd_valid2 = 1'b0;
      n_cmp++; if (wr_en2 !== 1'b1 || addr2 !== 2'(i)) begin n_bad++; $display("FAIL cap_write%0d: got wr=%b addr=%0d want 1/%0d", i, wr_en2, addr2, i); end
      n_cmp++; if (wdata2 !== exp_w) begin n_bad++; $display("FAIL cap_wdata%0d: got %h want %h", i, wdata2, exp_w); end
      @(posedge clk); #1;
      n_cmp++; if (count2 !== 3'(i + 1) || done2 !== (i == 3)) begin n_bad++; $display("FAIL cap_status%0d: got cnt=%0d done=%b want %0d/%b", i, count2, done2, i + 1, i == 3); end
    end
    @(negedge clk); cmd_valid2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (wr_en2 !== 1'b0 || cmd_ready2 !== 1'b0) begin n_bad++; $display("FAIL cap_fifth: got wr=%b rdy=%b want 0/0", wr_en2, cmd_ready2); end
    end
    cmd_valid2 = 1'b0;
    n_cmp++; if (count2 !== 3'd4) begin n_bad++; $display("FAIL cap_count: got %0d want 4", count2); end
  endtask

  task automatic test_start_mid_write();
    issue(2, 3, 4, 5, 0, 0, 0, 0, ref_word(2, 3, 4, 5, 0, 0, 0));
    @(negedge clk);
    set_fields(3, 9, 10, 11, 0, 0, 0, 0);
    cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0; start = 1'b1;
    n_cmp++; if (wr_en !== 1'b1 || addr !== 8'd1) begin n_bad++; $display("FAIL smw_write: got wr=%b addr=%0d want 1/1", wr_en, addr); end
    @(posedge clk); #1 start = 1'b0;
    n_cmp++; if (wr_en !== 1'b0 || addr !== 8'd0 || count !== 9'd0 || cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL smw_after: got wr=%b addr=%0d cnt=%0d rdy=%b want 0/0/0/1", wr_en, addr, count, cmd_ready);
    end
    m_addr = 0; m_count = 0; m_done = 0;
    issue(7, 1, 1, 1, 0, 0, 0, 0, ref_word(7, 1, 1, 1, 0, 0, 0));
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk);
    set_fields(21, 2, 3, 0, 0, 16'hBEEF, 0, 0);
    cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    n_cmp++; if (wr_en !== 1'b1) begin n_bad++; $display("FAIL rmw_pre: got %b want 1", wr_en); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if ({wr_en, busy, done, err} !== 4'b0) begin n_bad++; $display("FAIL rmw_flags: got %b want 0000", {wr_en, busy, done, err}); end
    n_cmp++; if (addr !== 8'd0 || count !== 9'd0 || wdata !== 32'd0) begin
      n_bad++; $display("FAIL rmw_regs: got addr=%0d cnt=%0d wdata=%h want 0/0/0", addr, count, wdata);
    end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b1 || wr_en !== 1'b0) begin n_bad++; $display("FAIL rmw_release: got rdy=%b wr=%b want 1/0", cmd_ready, wr_en); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_add();
    test_lw_sra();
    test_back_to_back();
    test_err();
    test_start_collision();
    test_random();
    test_capacity();
    test_start_mid_write();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
